// File: rtl/ddi_pkg.sv
// rtl/ddi_pkg.sv - shared types and constants for the 12-bit datapath blocks
package ddi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WORD_W = 12;

endpackage

// File: rtl/serializer12bit_bit_counter.sv
// rtl/serializer12bit_bit_counter.sv - modulo-WIDTH frame position counter with first/last flags
module bit_counter #(
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    output logic [$clog2(WIDTH)-1:0]   count,
    output logic                       is_first,
    output logic                       is_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    assign is_first = (count == '0);
    assign is_last  = (count == LAST);

    // Wraps only through the last position so the count never leaves 0..WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            if (is_last) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serializer12bit.sv
// rtl/serializer12bit.sv - parallel-in serial-out word transmitter with frame markers
module serializer12bit
    import ddi_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic             done
);

    state_t                     state;
    logic [WIDTH-1:0]           shreg;
    logic [$clog2(WIDTH)-1:0]   count;
    logic                       is_first;
    logic                       is_last;
    logic                       load;
    logic                       beat;

    assign load = (state == IDLE) && in_valid;
    assign beat = (state == SHIFT) && ser_ready;

    bit_counter #(
        .WIDTH(WIDTH)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (load),
        .en       (beat),
        .count    (count),
        .is_first (is_first),
        .is_last  (is_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= d_in;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        // Zero fill leaves shreg cleared after a full frame, so ser_out idles low.
                        if (MSB_FIRST != 0) begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                        end
                        if (is_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign ser_valid = (state == SHIFT);
    assign ser_out   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign ser_first = ser_valid && is_first;
    assign ser_last  = ser_valid && is_last;

    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_serializer12bit.sv
// tb/tb_serializer12bit.sv - self-checking bench for serializer12bit, MSB-first and LSB-first instances
module tb_serializer12bit;

    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  d_in;
    logic          in_valid;
    logic          ser_ready;

    logic in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, done_m;
    logic in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, done_l;

    int cmp_count = 0;
    int err_count = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serializer12bit #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready_m),
        .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
        .ser_first(ser_first_m), .ser_last(ser_last_m), .done(done_m)
    );

    serializer12bit #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready_l),
        .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
        .ser_first(ser_first_l), .ser_last(ser_last_l), .done(done_l)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: is a frame in flight, which word, how many bits already sent.
    bit          m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int          m_sent = 0;
    bit          m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_sent = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1;
                    m_word = d_in;
                    m_sent = 0;
                end
            end else if (ser_ready) begin
                m_sent++;
                if (m_sent == W) begin
                    m_busy = 1'b0;
                    m_sent = 0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_m, exp_l, exp_f, exp_z;
            exp_m = m_busy ? m_word[W-1-m_sent] : 1'b0;
            exp_l = m_busy ? m_word[m_sent] : 1'b0;
            exp_f = m_busy && (m_sent == 0);
            exp_z = m_busy && (m_sent == W - 1);
            check("in_ready_m",  W'(in_ready_m),  W'(!m_busy));
            check("ser_valid_m", W'(ser_valid_m), W'(m_busy));
            check("ser_out_m",   W'(ser_out_m),   W'(exp_m));
            check("ser_first_m", W'(ser_first_m), W'(exp_f));
            check("ser_last_m",  W'(ser_last_m),  W'(exp_z));
            check("done_m",      W'(done_m),      W'(m_done));
            check("in_ready_l",  W'(in_ready_l),  W'(!m_busy));
            check("ser_valid_l", W'(ser_valid_l), W'(m_busy));
            check("ser_out_l",   W'(ser_out_l),   W'(exp_l));
            check("ser_first_l", W'(ser_first_l), W'(exp_f));
            check("ser_last_l",  W'(ser_last_l),  W'(exp_z));
            check("done_l",      W'(done_l),      W'(m_done));
        end
    end

    // Receivers rebuild each word from the accepted bits, independent of the model.
    logic [W-1:0] rx_m, rx_l, word_m, word_l;
    int  frames = 0;
    int  beats_m = 0;
    int  dones_m = 0;
    int  dones_l = 0;
    logic first_bit_m, first_bit_l;

    always @(negedge clk) begin
        if (chk_en) begin
            if (done_m === 1'b1) dones_m++;
            if (done_l === 1'b1) dones_l++;
            if (!rst && ser_ready && ser_valid_m === 1'b1) begin
                if (ser_first_m === 1'b1) begin
                    beats_m = 0;
                    first_bit_m = ser_out_m;
                    first_bit_l = ser_out_l;
                end
                beats_m++;
                rx_m = {rx_m[W-2:0], ser_out_m};
                rx_l = {ser_out_l, rx_l[W-1:1]};
                if (ser_last_m === 1'b1) begin
                    word_m = rx_m;
                    word_l = rx_l;
                    frames++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        d_in = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        int n;
        n = 0;
        while (frames < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("frame_timeout", W'(frames >= target), W'(1));
    endtask

    logic [3:0] rdy_pat;
    int n;

    initial begin
        rst = 1'b1;
        d_in = '0;
        in_valid = 1'b0;
        ser_ready = 1'b1;
        rx_m = '0;
        rx_l = '0;
        word_m = '0;
        word_l = '0;
        first_bit_m = 1'b0;
        first_bit_l = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("idle_in_ready", W'(in_ready_m), W'(1));
        check("idle_done", W'(dones_m), W'(0));

        send(12'hA5C);
        wait_frame(1);
        check("word_a5c_m", word_m, 12'hA5C);
        check("word_a5c_l", word_l, 12'hA5C);
        check("first_bit_a5c_m", W'(first_bit_m), W'(1));
        step();
        check("done_after_a5c", W'(done_m), W'(1));
        repeat (3) step();

        send(12'h001);
        wait_frame(2);
        check("first_bit_001_l", W'(first_bit_l), W'(1));
        check("first_bit_001_m", W'(first_bit_m), W'(0));
        check("word_001_l", word_l, 12'h001);
        repeat (3) step();

        rdy_pat = 4'b1001;
        send(12'hFF0);
        n = 0;
        while (frames < 3 && n < 300) begin
            ser_ready = rdy_pat[n % 4];
            step();
            n++;
        end
        ser_ready = 1'b1;
        check("bp_timeout", W'(frames >= 3), W'(1));
        check("bp_beats", W'(beats_m), W'(12));
        check("word_ff0_m", word_m, 12'hFF0);
        check("word_ff0_l", word_l, 12'hFF0);
        repeat (4) step();
        check("bp_dones", W'(dones_m), W'(3));

        d_in = 12'h123;
        in_valid = 1'b1;
        step();
        repeat (5) step();
        d_in = 12'h456;
        wait_frame(4);
        check("word_123_m", word_m, 12'h123);
        check("word_123_l", word_l, 12'h123);
        step();
        check("b2b_gap_ready", W'(in_ready_m), W'(1));
        step();
        check("b2b_reload", W'(ser_valid_m), W'(1));
        in_valid = 1'b0;
        wait_frame(5);
        check("word_456_m", word_m, 12'h456);
        check("word_456_l", word_l, 12'h456);
        repeat (3) step();

        send(12'hABC);
        n = 0;
        while (beats_m < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", W'(ser_valid_m), W'(0));
        repeat (3) step();
        check("abort_no_done", W'(dones_m), W'(5));
        check("abort_frames", W'(frames), W'(5));

        send(12'h0F0);
        wait_frame(6);
        check("word_0f0_m", word_m, 12'h0F0);
        check("word_0f0_l", word_l, 12'h0F0);
        repeat (4) step();
        check("total_dones_m", W'(dones_m), W'(6));
        check("total_dones_l", W'(dones_l), W'(6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
